// File: rtl/lcd_win_ctrl.sv
// Windowed LCD pixel server: loads a raster image, then streams a WIN x WIN
// window whose origin and horizontal mirroring are steered by commands.
module lcd_win_ctrl #(
  parameter int DW    = 8,
  parameter int IMG_W = 6,
  parameter int IMG_H = 6,
  parameter int WIN   = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [DW-1:0] datain,
  input  logic [2:0]    cmd,
  input  logic          cmd_valid,
  output logic [DW-1:0] dataout,
  output logic          output_valid,
  output logic          busy
);

  localparam int NPIX = IMG_W * IMG_H;
  localparam int AW   = (NPIX > 1)  ? $clog2(NPIX)  : 1;
  localparam int RW   = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int CW   = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int WW   = (WIN > 1)   ? $clog2(WIN)   : 1;

  localparam int MAX_ROW = IMG_H - WIN;
  localparam int MAX_COL = IMG_W - WIN;
  localparam int DEF_ROW_RAW = (IMG_H / 2 > 0) ? IMG_H / 2 - 1 : 0;
  localparam int DEF_COL_RAW = (IMG_W / 2 > 0) ? IMG_W / 2 - 1 : 0;
  localparam int DEF_ROW = (DEF_ROW_RAW > MAX_ROW) ? MAX_ROW : DEF_ROW_RAW;
  localparam int DEF_COL = (DEF_COL_RAW > MAX_COL) ? MAX_COL : DEF_COL_RAW;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_MOVE = 2'd2;
  localparam logic [1:0] ST_OUT  = 2'd3;

  localparam logic [2:0] CMD_REFRESH = 3'd0;
  localparam logic [2:0] CMD_LOAD    = 3'd1;
  localparam logic [2:0] CMD_RIGHT   = 3'd2;
  localparam logic [2:0] CMD_LEFT    = 3'd3;
  localparam logic [2:0] CMD_UP      = 3'd4;
  localparam logic [2:0] CMD_DOWN    = 3'd5;
  localparam logic [2:0] CMD_MIRROR  = 3'd6;
  localparam logic [2:0] CMD_HOME    = 3'd7;

  logic [DW-1:0] img_mem [NPIX];

  logic [1:0]    state_reg;
  logic [2:0]    cmd_reg;
  logic          busy_reg;
  logic          output_valid_reg;
  logic [DW-1:0] dataout_reg;
  logic [RW-1:0] orow_reg, orow_next;
  logic [CW-1:0] ocol_reg, ocol_next;
  logic          mirror_reg, mirror_next;
  logic [AW-1:0] load_cnt_reg;
  logic [WW-1:0] win_r_reg, win_c_reg;

  logic [AW-1:0] rd_addr;
  logic          win_last;
  int            pix_row, pix_col;

  // Image store: write-only from LOAD, never reset so contents survive reset.
  always_ff @(posedge clk) begin
    if (state_reg == ST_LOAD)
      img_mem[load_cnt_reg] <= datain;
  end

  always_comb begin
    pix_row = int'(orow_reg) + int'(win_r_reg);
    if (mirror_reg)
      pix_col = int'(ocol_reg) + (WIN - 1 - int'(win_c_reg));
    else
      pix_col = int'(ocol_reg) + int'(win_c_reg);
    rd_addr = AW'(pix_row * IMG_W + pix_col);
  end

  assign win_last = (win_r_reg == WW'(WIN - 1)) && (win_c_reg == WW'(WIN - 1));

  // Origin/mirror update applied during the single MOVE cycle.
  always_comb begin
    orow_next   = orow_reg;
    ocol_next   = ocol_reg;
    mirror_next = mirror_reg;
    case (cmd_reg)
      CMD_RIGHT:  if (ocol_reg < CW'(MAX_COL)) ocol_next = ocol_reg + CW'(1);
      CMD_LEFT:   if (ocol_reg != '0)          ocol_next = ocol_reg - CW'(1);
      CMD_DOWN:   if (orow_reg < RW'(MAX_ROW)) orow_next = orow_reg + RW'(1);
      CMD_UP:     if (orow_reg != '0)          orow_next = orow_reg - RW'(1);
      CMD_MIRROR: mirror_next = ~mirror_reg;
      CMD_HOME: begin
        orow_next = RW'(DEF_ROW);
        ocol_next = CW'(DEF_COL);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg        <= ST_IDLE;
      cmd_reg          <= CMD_REFRESH;
      busy_reg         <= 1'b0;
      output_valid_reg <= 1'b0;
      dataout_reg      <= '0;
      orow_reg         <= RW'(DEF_ROW);
      ocol_reg         <= CW'(DEF_COL);
      mirror_reg       <= 1'b0;
      load_cnt_reg     <= '0;
      win_r_reg        <= '0;
      win_c_reg        <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          output_valid_reg <= 1'b0;
          if (cmd_valid && !busy_reg) begin
            cmd_reg      <= cmd;
            busy_reg     <= 1'b1;
            load_cnt_reg <= '0;
            win_r_reg    <= '0;
            win_c_reg    <= '0;
            if (cmd == CMD_REFRESH)
              state_reg <= ST_OUT;
            else if (cmd == CMD_LOAD)
              state_reg <= ST_LOAD;
            else
              state_reg <= ST_MOVE;
          end
        end
        ST_LOAD: begin
          load_cnt_reg <= load_cnt_reg + AW'(1);
          if (load_cnt_reg == AW'(NPIX - 1)) begin
            orow_reg   <= RW'(DEF_ROW);
            ocol_reg   <= CW'(DEF_COL);
            mirror_reg <= 1'b0;
            state_reg  <= ST_OUT;
          end
        end
        ST_MOVE: begin
          orow_reg   <= orow_next;
          ocol_reg   <= ocol_next;
          mirror_reg <= mirror_next;
          state_reg  <= ST_OUT;
        end
        default: begin
          // Registered read doubles as the output register.
          dataout_reg      <= img_mem[rd_addr];
          output_valid_reg <= 1'b1;
          if (win_last) begin
            win_r_reg <= '0;
            win_c_reg <= '0;
            busy_reg  <= 1'b0;
            state_reg <= ST_IDLE;
          end else if (win_c_reg == WW'(WIN - 1)) begin
            win_c_reg <= '0;
            win_r_reg <= win_r_reg + WW'(1);
          end else begin
            win_c_reg <= win_c_reg + WW'(1);
          end
        end
      endcase
    end
  end

  assign dataout      = dataout_reg;
  assign output_valid = output_valid_reg;
  assign busy         = busy_reg;

endmodule

// File: tb/tb_lcd_win_ctrl.sv
// Scoreboard bench for lcd_win_ctrl: a window model pushes expected pixels per
// command; an independent monitor pops and compares every valid output.
module tb_lcd_win_ctrl;

  localparam int DW    = 8;
  localparam int IMG_W = 6;
  localparam int IMG_H = 6;
  localparam int WIN   = 3;
  localparam int NPIX  = IMG_W * IMG_H;
  localparam int DEF_ROW = 2;
  localparam int DEF_COL = 2;

  logic          clk;
  logic          reset;
  logic [DW-1:0] datain;
  logic [2:0]    cmd;
  logic          cmd_valid;
  logic [DW-1:0] dataout;
  logic          output_valid;
  logic          busy;

  lcd_win_ctrl #(.DW(DW), .IMG_W(IMG_W), .IMG_H(IMG_H), .WIN(WIN)) dut (
    .clk(clk), .reset(reset), .datain(datain), .cmd(cmd), .cmd_valid(cmd_valid),
    .dataout(dataout), .output_valid(output_valid), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] pix;
    bit            last;
  } exp_t;

  exp_t          sb_q[$];
  int            checks = 0;
  int            errors = 0;

  logic [DW-1:0] img_m [NPIX];
  logic [DW-1:0] load_pix [NPIX];
  int            orow_m = DEF_ROW;
  int            ocol_m = DEF_COL;
  bit            mir_m = 0;

  function automatic void push_window();
    for (int r = 0; r < WIN; r++) begin
      for (int c = 0; c < WIN; c++) begin
        exp_t e;
        int col;
        col = mir_m ? (ocol_m + WIN - 1 - c) : (ocol_m + c);
        e.pix  = img_m[(orow_m + r) * IMG_W + col];
        e.last = (r == WIN - 1) && (c == WIN - 1);
        sb_q.push_back(e);
      end
    end
  endfunction

  function automatic void model_cmd(input logic [2:0] c, input bit ramp);
    case (c)
      3'd1: begin
        for (int i = 0; i < NPIX; i++) begin
          load_pix[i] = ramp ? DW'(i) : DW'($urandom);
          img_m[i] = load_pix[i];
        end
        orow_m = DEF_ROW; ocol_m = DEF_COL; mir_m = 0;
      end
      3'd2: if (ocol_m < IMG_W - WIN) ocol_m++;
      3'd3: if (ocol_m > 0) ocol_m--;
      3'd4: if (orow_m > 0) orow_m--;
      3'd5: if (orow_m < IMG_H - WIN) orow_m++;
      3'd6: mir_m = !mir_m;
      3'd7: begin orow_m = DEF_ROW; ocol_m = DEF_COL; end
      default: ;
    endcase
    push_window();
  endfunction

  // Monitor: one pop per valid output cycle, plus the hold check when valid drops.
  exp_t          mon_e;
  bit            prev_valid_m = 0;
  logic [DW-1:0] last_pix_m = '0;
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_valid_m = 0;
      end else begin
        if (output_valid) begin
          checks++;
          if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_pixel: got %0d, required no output", dataout);
          end else begin
            mon_e = sb_q.pop_front();
            if (dataout !== mon_e.pix) begin
              errors++;
              $display("FAIL pixel: got %0d, required %0d", dataout, mon_e.pix);
            end
            checks++;
            if (busy !== !mon_e.last) begin
              errors++;
              $display("FAIL busy_on_pixel: got %0b, required %0b", busy, !mon_e.last);
            end
          end
          last_pix_m = dataout;
        end else if (prev_valid_m) begin
          checks++;
          if (dataout !== last_pix_m) begin
            errors++;
            $display("FAIL dataout_hold: got %0d, required %0d", dataout, last_pix_m);
          end
        end
        prev_valid_m = output_valid;
      end
    end
  end

  task automatic issue(input logic [2:0] c, input bit ramp, input bit expect_now);
    int  n;
    int  edges;
    int  exp_lat;
    bit  prev;
    bit  acc;
    model_cmd(c, ramp);
    cmd = c;
    cmd_valid = 1'b1;
    n = 0;
    acc = 0;
    while (!acc && n < 200) begin
      prev = busy;
      @(negedge clk);
      n++;
      if (!prev && busy) acc = 1;
    end
    cmd_valid = 1'b0;
    cmd = 3'($urandom);
    checks++;
    if (!acc) begin
      errors++;
      $display("FAIL accept_timeout: cmd %0d not accepted in %0d cycles, required acceptance", c, n);
      return;
    end
    if (expect_now) begin
      checks++;
      if (n != 1) begin
        errors++;
        $display("FAIL accept_edge: accepted after %0d edges, required 1", n);
      end
    end
    edges = 0;
    if (c == 3'd1) begin
      for (int i = 0; i < NPIX; i++) begin
        datain = load_pix[i];
        @(negedge clk);
        edges++;
      end
      datain = DW'($urandom);
    end
    while (!output_valid && edges < 200) begin
      @(negedge clk);
      edges++;
    end
    exp_lat = (c == 3'd0) ? 1 : (c == 3'd1) ? NPIX + 1 : 2;
    checks++;
    if (edges != exp_lat) begin
      errors++;
      $display("FAIL latency: cmd %0d first pixel after %0d edges, required %0d", c, edges, exp_lat);
    end
    $display("cmd %0d accepted after %0d cycles, origin (%0d,%0d) mirror %0d", c, n, orow_m, ocol_m, mir_m);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (busy) begin
      errors++;
      $display("FAIL idle_timeout: busy still %0b, required 0", busy);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] rc;
    reset = 1'b1;
    cmd_valid = 1'b0;
    cmd = 3'd0;
    datain = '0;
    repeat (3) @(negedge clk);
    checks += 3;
    if (dataout !== '0)     begin errors++; $display("FAIL reset_dataout: got %0d, required 0", dataout); end
    if (output_valid !== 0) begin errors++; $display("FAIL reset_valid: got %0b, required 0", output_valid); end
    if (busy !== 0)         begin errors++; $display("FAIL reset_busy: got %0b, required 0", busy); end
    reset = 1'b0;

    // Ramp image, moves with saturation, mirror, home.
    issue(3'd1, 1, 1);
    wait_idle(); issue(3'd2, 0, 1);
    issue(3'd2, 0, 0);
    issue(3'd7, 0, 0);
    for (int i = 0; i < 3; i++) issue(3'd4, 0, 0);
    for (int i = 0; i < 3; i++) begin wait_idle(); issue(3'd3, 0, 1); end
    issue(3'd7, 0, 0);
    issue(3'd6, 0, 0);
    issue(3'd6, 0, 0);

    // Command held during an OUT sequence, then reset at the 4th output.
    issue(3'd0, 0, 0);
    issue(3'd2, 0, 0);
    issue(3'd6, 0, 0);
    issue(3'd5, 0, 0);
    wait_idle();
    issue(3'd0, 0, 1);
    repeat (3) @(negedge clk);
    #1;
    reset = 1'b1;
    sb_q.delete();
    orow_m = DEF_ROW; ocol_m = DEF_COL; mir_m = 0;
    #1;
    checks += 3;
    if (output_valid !== 0) begin errors++; $display("FAIL midrun_reset_valid: got %0b, required 0", output_valid); end
    if (busy !== 0)         begin errors++; $display("FAIL midrun_reset_busy: got %0b, required 0", busy); end
    if (dataout !== '0)     begin errors++; $display("FAIL midrun_reset_dataout: got %0d, required 0", dataout); end
    $display("reset asserted during window output");
    @(negedge clk);
    #1;
    reset = 1'b0;
    issue(3'd0, 0, 1);

    // Random command stream with random images.
    for (int k = 0; k < 40; k++) begin
      rc = 3'($urandom_range(0, 7));
      if (rc == 3'd1 && $urandom_range(0, 3) != 0) rc = 3'd0;
      if ($urandom_range(0, 1) == 1) begin
        wait_idle();
        issue(rc, 0, 1);
      end else begin
        issue(rc, 0, 0);
      end
    end

    wait_idle();
    repeat (3) @(negedge clk);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d pixels outstanding, required 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lcd_win_ctrl.md
LCD_WIN_CTRL -- requirements
Module: lcd_win_ctrl

Interface
REQ-001 Parameter DW, default 8: pixel width in bits.
REQ-002 Parameter IMG_W, default 6: image width in pixels.
REQ-003 Parameter IMG_H, default 6: image height in pixels.
REQ-004 Parameter WIN, default 3: square display-window edge in pixels; legal range 1 <= WIN <= min(IMG_W, IMG_H).
REQ-005 clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 datain  input  DW  image pixel; sampled only during LOAD.
REQ-008 cmd  input  3  command code; sampled only when accepted.
REQ-009 cmd_valid  input  1  command strobe.
REQ-010 dataout  output  DW  window pixel; registered.
REQ-011 output_valid  output  1  dataout holds a valid window pixel this cycle.
REQ-012 busy  output  1  command in progress; new commands not accepted.

Function
REQ-013 The block SHALL decode commands as: 0 REFRESH, 1 LOAD, 2 RIGHT, 3 LEFT, 4 UP, 5 DOWN, 6 MIRROR, 7 HOME.
REQ-014 The block SHALL hold an IMG_W*IMG_H x DW image store, raster order, address = row*IMG_W + col, plus window origin (orow, ocol) and a mirror flag.
REQ-015 FSM states: IDLE, LOAD, MOVE, OUT; IDLE is the reset state.
REQ-016 Accept: at an edge in IDLE with busy=0 and cmd_valid=1, latch cmd and set busy=1; cmd_valid SHALL be ignored while busy=1.
REQ-017 REFRESH SHALL go IDLE->OUT; first pixel valid at the 1st edge after the accept edge.
REQ-018 LOAD SHALL sample datain at the 1st..(IMG_W*IMG_H)th edges after the accept edge into addresses 0..IMG_W*IMG_H-1; then set orow=IMG_H/2-1, ocol=IMG_W/2-1 (integer division, floored at 0, clamped to the max origin), clear mirror, and enter OUT.
REQ-019 RIGHT/LEFT/DOWN/UP SHALL spend one MOVE cycle updating ocol+1/ocol-1/orow+1/orow-1, saturating at 0 and at IMG_W-WIN (col) or IMG_H-WIN (row); a saturated move SHALL still refresh.
REQ-020 MIRROR SHALL toggle the mirror flag in one MOVE cycle; HOME SHALL restore the LOAD default origin in one MOVE cycle, mirror unchanged; both then enter OUT.
REQ-021 Moves/MIRROR/HOME: first pixel valid at the 2nd edge after the accept edge.
REQ-022 OUT SHALL present WIN*WIN pixels on consecutive cycles, output_valid=1, window row r=0..WIN-1 outer, column c=0..WIN-1 inner; pixel = image[orow+r][ocol+c], or image[orow+r][ocol+WIN-1-c] when mirror=1.
REQ-023 busy SHALL fall at the same edge the last window pixel is presented; output_valid SHALL fall at the following edge, with dataout holding its last value.
REQ-024 The block SHALL accept a new command at the edge where output_valid falls (back-to-back operation).
REQ-025 Address arithmetic SHALL be sized ceil(log2(IMG_W*IMG_H)) bits minimum with no truncation for any legal parameter set.

Reset
REQ-026 Asserting reset SHALL immediately force IDLE, busy=0, output_valid=0, dataout=0, orow/ocol to the LOAD default, mirror=0, discarding any in-progress command.
REQ-027 Image store contents SHALL NOT be cleared by reset; they are undefined until the first complete LOAD.
REQ-028 After reset deasserts, the first rising edge SHALL accept a command.

Verification (defaults DW=8, IMG_W=IMG_H=6, WIN=3)
REQ-029 LOAD with pixels 0..35 -> 36 samples, then 9 outputs 14,15,16,20,21,22,26,27,28; busy falls with 28.
REQ-030 After REQ-029, RIGHT twice -> both refreshes output 15,16,17,21,22,23,27,28,29 (second saturated).
REQ-031 After REQ-029, UP three times then LEFT three times -> final output 0,1,2,6,7,8,12,13,14; HOME -> 14,...,28 pattern of REQ-029.
REQ-032 After REQ-029, MIRROR -> 16,15,14,22,21,20,28,27,26; MIRROR again -> original order.
REQ-033 cmd_valid=1 with cmd=2 held during an OUT sequence -> no origin change until accepted after busy falls; reset asserted at the 4th output -> output_valid=0, busy=0 immediately, a subsequent REFRESH outputs 14,...,28 pattern from retained image.
